// File: rtl/fpga_uart_sniffer_pkg.sv
// fpga_uart_sniffer_pkg: shared FSM state encoding and byte width for the UART RX sniffer
package fpga_uart_sniffer_pkg;
    localparam int DATA_W = 8;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
endpackage

// File: rtl/fpga_uart_sniffer_fifo.sv
// fpga_uart_sniffer_fifo: received-byte FIFO with registered storage
//   clk_i/rst_i : clock, synchronous active-high reset
//   push/din    : write request and byte; ignored when full unless a pop happens the same cycle
//   pop         : read request; ignored when empty
//   dout        : byte at the head (driven straight from the storage registers)
//   full/empty  : occupancy flags
//   count       : bytes buffered, 0..FIFO_DEPTH
module fpga_uart_sniffer_fifo
    import fpga_uart_sniffer_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push,
    input  logic [DATA_W-1:0]            din,
    input  logic                         pop,
    output logic [DATA_W-1:0]            dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(FIFO_DEPTH):0]  count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              do_push, do_pop;
    assign full    = count == (AW+1)'(FIFO_DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    // when full, a same-cycle pop frees the slot the write lands in (wr_ptr == rd_ptr)
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            mem    <= '{default: '0};
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/fpga_uart_rx_sniffer.sv
// fpga_uart_rx_sniffer: passive 8N1 UART receiver that buffers decoded bytes in a FIFO
//   clk_i/rst_i  : clock, synchronous active-high reset
//   rx_i         : asynchronous serial line, idle high
//   data_o       : byte at the FIFO head, valid_o qualifies it
//   ready_i      : consumer accept; a byte pops on valid_o && ready_i
//   frame_err_o  : one-cycle pulse after a stop bit sampled low
//   overrun_o    : sticky, a byte was dropped into a full FIFO
//   fifo_count_o : bytes buffered
module fpga_uart_rx_sniffer
    import fpga_uart_sniffer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 130,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         rx_i,
    output logic [DATA_W-1:0]            data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         frame_err_o,
    output logic                         overrun_o,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2);
    logic              rx_meta, rx_sync;
    state_t            state;
    logic [CW-1:0]     bit_cnt;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              stop_hit, push, full, empty;
    assign stop_hit = state == STOP && bit_cnt == LAST;
    assign push     = stop_hit && rx_sync;
    assign valid_o  = !empty;
    fpga_uart_sniffer_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .din   (shreg),
        .pop   (ready_i),
        .dout  (data_o),
        .full  (full),
        .empty (empty),
        .count (fifo_count_o)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            state       <= IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            rx_meta     <= rx_i;
            rx_sync     <= rx_meta;
            frame_err_o <= stop_hit && !rx_sync;
            // a pop in the same cycle makes room, so only a push with no pop is lost
            if (push && full && !ready_i)
                overrun_o <= 1'b1;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (!rx_sync)
                        state <= START;
                end
                START: begin
                    if (bit_cnt == MID) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? IDLE : DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt == LAST) begin
                        bit_cnt <= '0;
                        shreg   <= {rx_sync, shreg[DATA_W-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_cnt == LAST) begin
                        bit_cnt <= '0;
                        state   <= rx_sync ? IDLE : WAIT_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_sync)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpga_uart_rx_sniffer.sv
// tb_fpga_uart_rx_sniffer: directed table plus corner sequences for the UART RX sniffer
module tb_fpga_uart_rx_sniffer;
    import fpga_uart_sniffer_pkg::*;

    localparam int CPB = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid, ferr, ovr;
    logic [2:0] cnt;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] rx_q[$];
    int         ferr_cnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_n;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    fpga_uart_rx_sniffer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_i         (rx),
        .data_o       (data),
        .valid_o      (valid),
        .ready_i      (ready),
        .frame_err_o  (ferr),
        .overrun_o    (ovr),
        .fifo_count_o (cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready)
                rx_q.push_back(data);
            if (ferr)
                ferr_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
        tick(4);
    endtask

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1, 8'h55, 0};
        vecs[1] = '{8'hA5, 1'b0, 0, 8'h00, 1};
        vecs[2] = '{8'h3C, 1'b1, 1, 8'h3C, 0};
        vecs[3] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[4] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vecs[5] = '{8'h80, 1'b1, 1, 8'h80, 0};

        tick(3);
        check("rst_valid", valid, 0);
        check("rst_data", data, 8'h00);
        check("rst_ferr", ferr, 0);
        check("rst_ovr", ovr, 0);
        check("rst_count", cnt, 0);
        rst = 1'b0;
        tick(3);

        for (int v = 0; v < 6; v++) begin
            rx_q.delete();
            ferr_cnt = 0;
            send_byte(vecs[v].data, vecs[v].stop);
            tick(4);
            check($sformatf("vec%0d_npop", v), rx_q.size(), vecs[v].exp_n);
            if (rx_q.size() > 0)
                check($sformatf("vec%0d_data", v), rx_q[0], vecs[v].exp_data);
            check($sformatf("vec%0d_ferr", v), ferr_cnt, vecs[v].exp_ferr);
            check($sformatf("vec%0d_valid", v), valid, 0);
        end

        rx_q.delete();
        ferr_cnt = 0;
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(30);
        check("glitch_npop", rx_q.size(), 0);
        check("glitch_ferr", ferr_cnt, 0);
        check("glitch_state", 32'(dut.state), 32'(IDLE));

        rx_q.delete();
        ready = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            send_byte(8'(b), 1'b1);
            check($sformatf("ovr_after_%0d", b), ovr, (b == 5) ? 1 : 0);
        end
        check("ovr_count", cnt, 4);
        check("ovr_valid", valid, 1);
        check("ovr_head_stable", data, 8'h01);
        check("ovr_npop_held", rx_q.size(), 0);
        ready = 1'b1;
        tick(10);
        check("ovr_npop", rx_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < rx_q.size())
                check($sformatf("ovr_order%0d", i), rx_q[i], 8'(i + 1));
        check("ovr_sticky", ovr, 1);
        check("ovr_drained", cnt, 0);

        rx_q.delete();
        ferr_cnt = 0;
        rx = 1'b0;
        tick(CPB * 4 + 12);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(CPB * 5 + 10);
        check("abort_npop", rx_q.size(), 0);
        check("abort_ferr", ferr_cnt, 0);
        check("abort_ovr", ovr, 0);
        check("abort_count", cnt, 0);
        check("abort_state", 32'(dut.state), 32'(IDLE));
        send_byte(8'h0F, 1'b1);
        tick(4);
        check("abort_next_npop", rx_q.size(), 1);
        if (rx_q.size() > 0)
            check("abort_next_data", rx_q[0], 8'h0F);
        check("abort_next_ferr", ferr_cnt, 0);
        check("abort_next_ovr", ovr, 0);

        rx_q.delete();
        ready = 1'b0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        check("full_count", cnt, 4);
        fork
            send_byte(8'h55, 1'b1);
            begin
                logic found;
                found = 1'b0;
                for (int k = 0; k < 400 && !found; k++) begin
                    if (dut.state == STOP && dut.bit_cnt == 4'(CPB - 1))
                        found = 1'b1;
                    else
                        tick(1);
                end
                check("full_sync_found", found, 1);
                if (found) begin
                    ready = 1'b1;
                    tick(1);
                    ready = 1'b0;
                end
            end
        join
        check("full_pp_count", cnt, 4);
        check("full_pp_ovr", ovr, 0);
        check("full_pp_npop", rx_q.size(), 1);
        ready = 1'b1;
        tick(10);
        check("full_total", rx_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < rx_q.size())
                check($sformatf("full_order%0d", i), rx_q[i], 8'h11 * 8'(i + 1));
        check("full_end_count", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fpga_uart_rx_sniffer.md
FPGA_UART_RX_SNIFFER -- requirements
Module: fpga_uart_rx_sniffer

Interface
- REQ-001: The block SHALL use parameter CLKS_PER_BIT, default 130, the clk_i cycles per UART bit (15 MHz / 115200).
- REQ-002: The block SHALL use parameter FIFO_DEPTH, default 16, the received-byte buffer depth (power of two, >=2).
- REQ-003: Port clk_i, input, 1, is the single clock; all logic is rising-edge.
- REQ-004: Port rst_i, input, 1, is the reset: synchronous, active-high.
- REQ-005: Port rx_i, input, 1, is the asynchronous serial line, driven by the SoC's uart_tx_o; idle high.
- REQ-006: Port data_o, output, 8, is the byte at the FIFO head.
- REQ-007: Port valid_o, output, 1, indicates that data_o holds a byte.
- REQ-008: Port ready_i, input, 1, is the consumer accept signal.
- REQ-009: Port frame_err_o, output, 1, is a one-cycle pulse on a bad stop bit.
- REQ-010: Port overrun_o, output, 1, is sticky and indicates that a byte was dropped because the FIFO was full.
- REQ-011: Port fifo_count_o, output, $clog2(FIFO_DEPTH)+1, is the number of bytes buffered.

Function
- REQ-012: rx_i SHALL pass through a 2-flop synchronizer whose flops reset to 1; all decoding uses the synchronized value.
- REQ-013: The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_IDLE, with one bit counter (0..CLKS_PER_BIT-1) and one bit index (0..7).
- REQ-014: IDLE -> START when the synchronized line is 0; the bit counter clears.
- REQ-015: START: at count CLKS_PER_BIT/2 (integer division), a line value of 0 -> DATA with the counter cleared; a line value of 1 -> IDLE (glitch, no output).
- REQ-016: DATA: each bit is sampled when the counter reaches CLKS_PER_BIT-1 and then clears, LSB first; after bit 7 the FSM goes to STOP.
- REQ-017: STOP: sample at count CLKS_PER_BIT-1; 1 -> push the byte and go to IDLE; 0 -> frame_err_o=1 for exactly that cycle, discard the byte, go to WAIT_IDLE.
- REQ-018: WAIT_IDLE -> IDLE on the first cycle the synchronized line is 1.
- REQ-019: valid_o SHALL rise the cycle after the stop-bit sample cycle when the FIFO was previously empty.
- REQ-020: Handshake: a byte is popped on a cycle with valid_o&&ready_i; data_o and valid_o stay stable while valid_o&&!ready_i.
- REQ-021: A push into a full FIFO without a simultaneous pop SHALL drop the byte, leave the contents unchanged, and set overrun_o to 1 until reset.
- REQ-022: A push and pop in the same cycle SHALL both take effect, including when full, leaving fifo_count_o unchanged.
- REQ-023: The FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_count_o ranges 0..FIFO_DEPTH.
- REQ-024: Only frame_err_o and the FIFO push depend on the stop sample; data_o comes from a registered FIFO head with no combinational path from rx_i.

Reset
- REQ-025: On rst_i=1 at a clock edge: FSM=IDLE; counters=0; FIFO empty; valid_o=0, data_o=0x00, frame_err_o=0, overrun_o=0, fifo_count_o=0.
- REQ-026: Reset mid-frame SHALL abandon the partial byte; if rx_i is still low after reset, the FSM SHALL treat it as a new start bit, and the START glitch filter governs.

Structure
- REQ-027: A shared package fpga_uart_sniffer_pkg SHALL hold the FSM state enum and the data width constant (8).
- REQ-028: The FIFO SHALL be a sub-module named fpga_uart_sniffer_fifo (parameter FIFO_DEPTH; push, pop, full, empty and count), and the FSM and sampler SHALL stay in the top.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
- REQ-029: Send 0x55 with ready_i=1 -> exactly one valid_o cycle with data_o=0x55; frame_err_o=0 throughout.
- REQ-030: Drive rx_i low for 5 cycles then high -> no valid_o, no frame_err_o, and the FSM returns to IDLE.
- REQ-031: Send 0xA5 with the stop bit forced 0, then 0x3C -> one frame_err_o pulse, no 0xA5 output, then data_o=0x3C.
- REQ-032: ready_i=0; send 0x01..0x05 -> fifo_count_o=4 and overrun_o=1; then ready_i=1 -> outputs 0x01,0x02,0x03,0x04 in order; overrun_o stays 1.
- REQ-033: Pulse rst_i during DATA bit 3 of 0xF0, then send 0x0F -> no output from the aborted byte, data_o=0x0F, and all flags 0.
- REQ-034: Fill the FIFO to 4 entries, then hold ready_i=1 while the fifth byte's push coincides with a pop -> count stays 4, no overrun, and byte order is preserved.
